// File: rtl/wired_or_bus_arbiter_if.sv
// Bundle of request, release, drain and grant signals between the core requesters and the
// round-robin arbiter that owns the shared wired-OR bus.
interface wired_or_bus_arbiter_if #(
    parameter int NUM_CORES = 32
);
    localparam int ID_W = $clog2(NUM_CORES);

    // Handshake: a core holds core_req[i] high while it wants the bus. It owns the bus from the
    // first cycle grant[i] reads 1 until it pulses core_done[i] or drops core_req[i]. Only the
    // owner's done/req bits are looked at. drain blocks new grants, and drained reports quiescence.
    logic [NUM_CORES-1:0] core_req;
    logic [NUM_CORES-1:0] core_done;
    logic                 drain;
    logic [NUM_CORES-1:0] grant;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic                 timeout_err;
    logic                 drained;

    modport master (
        input  core_req,
        input  core_done,
        input  drain,
        output grant,
        output grant_valid,
        output grant_id,
        output timeout_err,
        output drained
    );

    modport slave (
        output core_req,
        output core_done,
        output drain,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  timeout_err,
        input  drained
    );
endinterface

// File: rtl/wired_or_bus_arbiter.sv
// Round-robin owner selection for the shared wired-OR bus. The grant is registered, the hold
// time is bounded, and a dead cycle is forced between owners.
module wired_or_bus_arbiter #(
    parameter int NUM_CORES = 32,
    parameter int MAX_HOLD  = 64,
    localparam int ID_W     = $clog2(NUM_CORES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    wired_or_bus_arbiter_if.master   bus,
    output logic [1:0]               dbg_state_o
);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 drained_q, drained_d;

    logic                 win_found;
    logic [ID_W-1:0]      win_id;
    logic                 own_done;
    logic                 own_req;
    logic                 hold_max;
    logic                 release_own;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return s[ID_W-1:0];
    endfunction

    // First requester at or after rr_ptr, wrapping once around the ring.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int off = 0; off < NUM_CORES; off++) begin
            if (!win_found && bus.core_req[wrap_add(rr_ptr_q, off)]) begin
                win_found = 1'b1;
                win_id    = wrap_add(rr_ptr_q, off);
            end
        end
    end

    assign own_done    = bus.core_done[grant_id_q];
    assign own_req     = bus.core_req[grant_id_q];
    assign hold_max    = (hold_cnt_q == CNT_W'(MAX_HOLD));
    assign release_own = own_done || !own_req || hold_max;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        drained_d  = bus.drain && (state_q == ST_IDLE) && (bus.core_req == '0);

        case (state_q)
            ST_IDLE: begin
                if (!bus.drain && win_found) begin
                    state_d    = ST_OWN;
                    grant_d    = NUM_CORES'(1) << win_id;
                    grant_id_d = win_id;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            ST_OWN: begin
                if (release_own) begin
                    state_d    = ST_TURN;
                    grant_d    = '0;
                    grant_id_d = '0;
                    rr_ptr_d   = wrap_add(grant_id_q, 1);
                    hold_cnt_d = '0;
                    // Flag only releases forced by the hold limit, not voluntary ones.
                    timeout_d  = hold_max && own_req && !own_done;
                end else if (!hold_max) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
            drained_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
            drained_q  <= drained_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout_err = timeout_q;
    assign bus.drained     = drained_q;
    assign dbg_state_o     = state_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
    a_no_direct_handover: assert property (@(posedge clk) disable iff (!rst_n)
        (|grant_q) |=> ((grant_q == $past(grant_q)) || (grant_q == '0)));
endmodule

// File: tb/tb_wired_or_bus_arbiter.sv
// Directed scenarios and random traffic for wired_or_bus_arbiter, checked every cycle
// against a cycle-level behavioural model of ownership, turnaround and drain.
module tb_wired_or_bus_arbiter;
    localparam int N        = 32;
    localparam int MAX_HOLD = 64;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] dbg_state;

    wired_or_bus_arbiter_if #(.NUM_CORES(N)) bus ();

    wired_or_bus_arbiter #(.NUM_CORES(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          cmp_en   = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = none), cycles held, a pending dead cycle, pointer.
    int m_owner   = -1;
    int m_held    = 0;
    int m_ptr     = 0;
    bit m_turn    = 1'b0;
    bit m_timeout = 1'b0;
    bit m_drained = 1'b0;
    bit m_d, m_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_held = 0; m_ptr = 0;
            m_turn = 1'b0; m_timeout = 1'b0; m_drained = 1'b0;
        end else begin
            m_drained = bus.drain && (m_owner < 0) && !m_turn && (bus.core_req == '0);
            m_timeout = 1'b0;
            if (m_owner >= 0) begin
                m_d = bus.core_done[m_owner];
                m_r = bus.core_req[m_owner];
                if (m_d || !m_r || m_held == MAX_HOLD) begin
                    m_timeout = !m_d && m_r;
                    m_ptr     = (m_owner + 1) % N;
                    m_owner   = -1;
                    m_turn    = 1'b1;
                end else begin
                    m_held++;
                end
            end else if (m_turn) begin
                m_turn = 1'b0;
            end else if (!bus.drain) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && bus.core_req[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_held  = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("grant", bus.grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("grant_valid", 32'(bus.grant_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
            check("grant_id", 32'(bus.grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            check("timeout_err", 32'(bus.timeout_err), 32'(m_timeout));
            check("drained", 32'(bus.drained), 32'(m_drained));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.core_req  = '0;
        bus.core_done = '0;
        bus.drain     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output int id, output int gap);
        gap = 0;
        while (!bus.grant_valid && gap < 40) begin
            step();
            gap++;
        end
        check("grant_wait", 32'(bus.grant_valid), 32'd1);
        id = bus.grant_valid ? int'(bus.grant_id) : -1;
    endtask

    task automatic wait_release();
        int n;
        n = 0;
        while (bus.grant_valid && n < 200) begin
            step();
            n++;
        end
        check("release_wait", 32'(bus.grant_valid), 32'd0);
    endtask

    initial begin
        int id, gap, held;
        logic [31:0] exp_id;
        bus.core_req  = '0;
        bus.core_done = '0;
        bus.drain     = 1'b0;
        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        step(); step(); step();
        check("rst_grant", bus.grant, 32'd0);
        check("rst_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_id", 32'(bus.grant_id), 32'd0);
        check("rst_drained", 32'(bus.drained), 32'd0);
        check("rst_timeout", 32'(bus.timeout_err), 32'd0);
        rst_n = 1'b1;

        // T1: asynchronous reset in the middle of an ownership
        bus.core_req = 32'h10;
        step();
        check("t1_grant", bus.grant, 32'h10);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_grant", bus.grant, 32'd0);
        check("t1_async_id", 32'(bus.grant_id), 32'd0);
        bus.core_req = 32'h3;
        step();
        rst_n = 1'b1;
        step();
        check("t1_regrant", bus.grant, 32'h1);
        bus.core_req = '0;
        wait_release();
        step();

        // T2: full rotation with everyone requesting
        do_reset();
        bus.core_req = '1;
        for (int i = 0; i <= N; i++) exp_q.push_back(32'(i % N));
        for (int i = 0; i <= N; i++) begin
            wait_grant(id, gap);
            exp_id = exp_q.pop_front();
            check("t2_id", 32'(id), exp_id);
            if (i > 0) check("t2_gap", 32'(gap), 32'd2);
            step(); step(); step();
            if (id >= 0) bus.core_done = 32'd1 << id;
            step();
            bus.core_done = '0;
        end
        bus.core_req = '0;
        wait_release();
        step(); step();

        // T3: pointer wrap from 31 back to 2
        do_reset();
        bus.core_req = 32'h4000_0000;
        wait_grant(id, gap);
        check("t3_first", 32'(id), 32'd30);
        bus.core_req = 32'h8000_0004;
        wait_release();
        wait_grant(id, gap);
        check("t3_wrap_hi", 32'(id), 32'd31);
        bus.core_req = 32'h0000_0004;
        wait_release();
        wait_grant(id, gap);
        check("t3_wrap_lo", 32'(id), 32'd2);
        bus.core_req = '0;
        wait_release();
        step(); step();

        // T4: forced release after the hold limit
        do_reset();
        bus.core_req = 32'h60;
        wait_grant(id, gap);
        check("t4_owner", 32'(id), 32'd5);
        held = 0;
        while (bus.grant_valid && held < 200) begin
            held++;
            step();
        end
        check("t4_hold_cycles", 32'(held), 32'(MAX_HOLD));
        check("t4_timeout_pulse", 32'(bus.timeout_err), 32'd1);
        step();
        check("t4_timeout_clear", 32'(bus.timeout_err), 32'd0);
        wait_grant(id, gap);
        check("t4_next_owner", 32'(id), 32'd6);
        bus.core_req = '0;
        wait_release();
        step(); step();

        // T5: drain lets the owner finish, then blocks until released
        do_reset();
        bus.core_req = 32'h80;
        wait_grant(id, gap);
        check("t5_owner", 32'(id), 32'd7);
        bus.drain    = 1'b1;
        bus.core_req = '1;
        step(); step();
        check("t5_owner_kept", bus.grant, 32'h80);
        bus.core_done = 32'h80;
        step();
        bus.core_done = '0;
        repeat (5) step();
        check("t5_no_grant", 32'(bus.grant_valid), 32'd0);
        check("t5_not_drained", 32'(bus.drained), 32'd0);
        bus.core_req = '0;
        step();
        check("t5_drained", 32'(bus.drained), 32'd1);
        bus.drain    = 1'b0;
        bus.core_req = 32'h100;
        step();
        check("t5_after_drain", bus.grant, 32'h100);
        check("t5_drained_drop", 32'(bus.drained), 32'd0);
        bus.core_req = '0;
        wait_release();
        step(); step();

        // T6: non-owner done/req activity is ignored
        do_reset();
        bus.core_req = 32'h8;
        wait_grant(id, gap);
        for (int i = 0; i < 10; i++) begin
            bus.core_req  = 32'h8 | ((i % 2 == 1) ? 32'h10 : 32'h0);
            bus.core_done = 32'h10;
            step();
            check("t6_grant", bus.grant, 32'h8);
        end
        bus.core_done = '0;
        bus.core_req  = '0;
        wait_release();
        step(); step();

        // Random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(31) == 0) begin
                case ($urandom_range(3))
                    0: bus.core_req = '0;
                    1: bus.core_req = $urandom;
                    2: bus.core_req = $urandom & $urandom & $urandom;
                    default: bus.core_req = 32'd1 << $urandom_range(N - 1);
                endcase
            end
            if (bus.grant_valid && $urandom_range(40) == 0) bus.core_done = bus.grant;
            else if ($urandom_range(7) == 0) bus.core_done = $urandom;
            else bus.core_done = '0;
            if ($urandom_range(63) == 0) bus.drain = ~bus.drain;
            if ($urandom_range(1999) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            step();
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
